// File: rtl/tc_pkg.sv
// Shared definitions for the indirect-branch target cache update path.
//   TC_INDEX_W   : index width of one target cache bank (64 entries)
//   TC_NUM_BANKS : number of banks, selected by pc[3:2]
//   BHR_W        : branch history width carried with each update
//   tc_upd_t     : one pending write {pc, target, bhr}
//   tc_state_e   : controller state (IDLE / DRAIN / CLEAR)
package tc_pkg;

  localparam int TC_INDEX_W   = 6;
  localparam int TC_NUM_BANKS = 4;
  localparam int BHR_W        = 10;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      target;
    logic [BHR_W-1:0] bhr;
  } tc_upd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } tc_state_e;

endpackage

// File: rtl/tc_update_fifo.sv
// In-order update queue: two write lanes, one read per cycle.
//   clk, reset          : clock, synchronous active-high reset
//   flush               : discard all entries this cycle
//   wr0_en / wr0_data   : first write lane (older entry)
//   wr1_en / wr1_data   : second write lane, only honoured with wr0_en
//   rd_en               : pop the head entry if one exists
//   space               : free slots counting this cycle's pop
//   full                : registered, occupancy == FIFO_DEPTH
//   nxt_vld / nxt_head  : head entry as it will be after this clock edge,
//                         used by the owner to fill its output register
module tc_update_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 74,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CW        = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr0_en,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rd_en,
  output logic [CW-1:0]     space,
  output logic              full,
  output logic              nxt_vld,
  output logic [DATA_W-1:0] nxt_head
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CW-1:0]     count;

  logic              rd_go;
  logic              wr0_go;
  logic              wr1_go;
  logic [CW-1:0]     remain;
  logic [CW-1:0]     count_n;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [PTR_W-1:0]  wr_ptr_n;
  logic [PTR_W-1:0]  wr_ptr1;

  always_comb begin
    rd_go    = rd_en && (count != '0);
    wr0_go   = wr0_en && !flush;
    wr1_go   = wr0_en && wr1_en && !flush;
    space    = CW'(FIFO_DEPTH) - count + CW'(rd_go);
    remain   = count - CW'(rd_go);
    wr_ptr1  = wr_ptr + 1'b1;
    if (flush) begin
      count_n  = '0;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
    end else begin
      count_n  = remain + CW'(wr0_go) + CW'(wr1_go);
      rd_ptr_n = rd_ptr + PTR_W'(rd_go);
      wr_ptr_n = wr_ptr + PTR_W'(wr0_go) + PTR_W'(wr1_go);
    end
    nxt_vld  = (count_n != '0);
    // With nothing left behind the popped head, the next head is the entry
    // being written on lane 0 this cycle (it lands at rd_ptr_n).
    nxt_head = (remain != '0) ? mem[rd_ptr_n] : wr0_data;
  end

  // ---- stage boundary: queue control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
      full   <= (count_n == CW'(FIFO_DEPTH));
    end
  end

  // ---- stage boundary: queue storage (data, no reset) ----
  always_ff @(posedge clk) begin
    if (wr0_go) mem[wr_ptr]  <= wr0_data;
    if (wr1_go) mem[wr_ptr1] <= wr1_data;
  end

endmodule

// File: rtl/target_cache_update_ctrl.sv
// Target cache write sequencer. Merges up to two retire-side updates per
// cycle into an in-order queue, drains one per cycle onto the cache write
// port, and runs a full-table clear (4 banks x 2^INDEX_W entries).
//   clk, reset             : clock, synchronous active-high reset
//   req0_* / req1_*        : retire slot 0 (older) / slot 1 (younger) update
//   clear_req              : one-cycle pulse, start (or restart) the clear
//   upd_en/pc/target/bhr   : registered write port into the target cache
//   clear_busy             : clear in progress, lookups must miss
//   q_full                 : queue holds FIFO_DEPTH entries
//   drop_cnt               : saturating count of requests lost to a full queue
// BHR_W must match tc_pkg::BHR_W since queue entries use tc_upd_t.
module target_cache_update_ctrl
  import tc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_W    = TC_INDEX_W,
  parameter int BHR_W      = tc_pkg::BHR_W,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [31:0]      req0_pc,
  input  logic [31:0]      req0_target,
  input  logic [BHR_W-1:0] req0_bhr,
  input  logic             req1_valid,
  input  logic [31:0]      req1_pc,
  input  logic [31:0]      req1_target,
  input  logic [BHR_W-1:0] req1_bhr,
  input  logic             clear_req,
  output logic             upd_en,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic [BHR_W-1:0] upd_bhr,
  output logic             clear_busy,
  output logic             q_full,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int CLR_W = 2 + INDEX_W;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = $bits(tc_upd_t);

  // Clear write k: bank = k[1:0] via pc[3:2], index = k[CLR_W-1:2] via the
  // history bits. pc[28:9] stays zero so the cache hash reduces to that index.
  function automatic tc_upd_t clear_entry(input logic [CLR_W-1:0] c);
    tc_upd_t e;
    e                  = '0;
    e.pc[3:2]          = c[1:0];
    e.bhr[INDEX_W-1:0] = c[CLR_W-1:2];
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  tc_state_e         state;
  tc_state_e         state_n;
  logic [CLR_W-1:0]  clr_cnt;
  logic [CLR_W-1:0]  clr_cnt_n;
  tc_upd_t           upd_q;
  tc_upd_t           upd_n;
  logic              upd_en_n;

  tc_upd_t           ent0;
  tc_upd_t           ent1;
  tc_upd_t           lane0;
  logic              in_clear;
  logic              clr_last;
  logic              accept_win;
  logic [1:0]        nreq;
  logic              acc0;
  logic              acc1;
  logic [1:0]        ndrop;
  logic [CW-1:0]     space;
  logic              fifo_full;
  logic              nxt_vld;
  logic [ENT_W-1:0]  nxt_head;

  assign ent0 = '{pc: req0_pc, target: req0_target, bhr: req0_bhr};
  assign ent1 = '{pc: req1_pc, target: req1_target, bhr: req1_bhr};

  always_comb begin
    in_clear   = (state == CLEAR);
    clr_last   = (clr_cnt == '1);
    // Requests are taken outside a clear and in its final write cycle; a
    // clear pulse discards whatever arrives alongside it.
    accept_win = !clear_req && (!in_clear || clr_last);
    nreq       = {1'b0, req0_valid} + {1'b0, req1_valid};
    // Compact to program order: a lone slot 1 request uses lane 0.
    lane0      = req0_valid ? ent0 : ent1;
    acc0       = accept_win && (nreq != 2'd0) && (space != '0);
    acc1       = accept_win && (nreq == 2'd2) && (space >= CW'(2));
    ndrop      = accept_win ? (nreq - {1'b0, acc0} - {1'b0, acc1}) : 2'd0;
  end

  tc_update_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (ENT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear_req),
    .wr0_en   (acc0),
    .wr0_data (lane0),
    .wr1_en   (acc1),
    .wr1_data (ent1),
    .rd_en    (!in_clear),
    .space    (space),
    .full     (fifo_full),
    .nxt_vld  (nxt_vld),
    .nxt_head (nxt_head)
  );

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    upd_en_n  = 1'b0;
    upd_n     = '0;
    if (clear_req) begin
      state_n   = CLEAR;
      clr_cnt_n = '0;
      upd_en_n  = 1'b1;
      upd_n     = clear_entry('0);
    end else if (in_clear && !clr_last) begin
      state_n   = CLEAR;
      clr_cnt_n = clr_cnt + 1'b1;
      upd_en_n  = 1'b1;
      upd_n     = clear_entry(clr_cnt + 1'b1);
    end else begin
      state_n  = nxt_vld ? DRAIN : IDLE;
      upd_en_n = nxt_vld;
      upd_n    = nxt_vld ? tc_upd_t'(nxt_head) : '0;
    end
  end

  // ---- stage boundary: registered write port, state and drop counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      upd_en   <= 1'b0;
      upd_q    <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      clr_cnt  <= clr_cnt_n;
      upd_en   <= upd_en_n;
      upd_q    <= upd_n;
      drop_cnt <= sat_add(drop_cnt, ndrop);
    end
  end

  assign upd_pc     = upd_q.pc;
  assign upd_target = upd_q.target;
  assign upd_bhr    = upd_q.bhr;
  assign clear_busy = in_clear;
  assign q_full     = fifo_full;

endmodule
